// File: rtl/mem8x8_ctrl.sv
// Sequencer for an 8x8 byte-cell array: SETUP/ACCESS/RELEASE handshake per access.
// Optional write-verify pass enabled by defining MEM8X8_CTRL_READBACK_EN.
module mem8x8_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_op,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [7:0] mem_sel,
  output logic       mem_op,
  output logic [7:0] mem_inp,
  input  logic [7:0] mem_outp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [2:0] CNT_RELOAD = 3'(WAIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       op_q, op_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;

`ifdef MEM8X8_CTRL_READBACK_EN
  logic pass_q, pass_d;
  logic err_q, err_d;
  logic rb_pending;
  // A write whose verify pass has not yet run.
  assign rb_pending = op_q & ~pass_q;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef MEM8X8_CTRL_READBACK_EN
    pass_d  = pass_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_RELOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = RELEASE;
`ifdef MEM8X8_CTRL_READBACK_EN
          if (pass_q) err_d = (mem_outp != wdata_q);
`endif
          // op_q is still 1 during a verify pass, so rdata is left alone there.
          if (!op_q) rdata_d = mem_outp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RELEASE: begin
`ifdef MEM8X8_CTRL_READBACK_EN
        if (rb_pending) begin
          pass_d  = 1'b1;
          state_d = SETUP;
        end else begin
          pass_d  = 1'b0;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 8'h00;
      cnt_q   <= 3'd0;
      rdata_q <= 8'h00;
`ifdef MEM8X8_CTRL_READBACK_EN
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef MEM8X8_CTRL_READBACK_EN
      pass_q  <= pass_d;
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode straight from registers so reset clears them without an edge.
  assign ready   = (state_q == IDLE);
  assign mem_sel = (state_q == ACCESS) ? (8'd1 << addr_q) : 8'd0;
  assign mem_inp = wdata_q;
  assign rdata   = rdata_q;
`ifdef MEM8X8_CTRL_READBACK_EN
  assign done    = (state_q == RELEASE) && !rb_pending;
  assign mem_op  = op_q & ~pass_q;
  assign err     = err_q;
`else
  assign done    = (state_q == RELEASE);
  assign mem_op  = op_q;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Bench for mem8x8_ctrl: two instances (WAIT_CYCLES=1 and 7) each driving a byte-cell array model.
// Build with MEM8X8_CTRL_READBACK_EN defined to exercise the write-verify pass.
module tb_mem8x8_ctrl;

`ifdef MEM8X8_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req [2];
  logic       req_op [2];
  logic [2:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic       ready [2];
  logic       done [2];
  logic       err [2];
  logic       mem_op [2];
  logic [7:0] rdata [2];
  logic [7:0] mem_sel [2];
  logic [7:0] mem_inp [2];
  logic [7:0] mem_outp [2];
  logic [7:0] corrupt [2];

  int tests = 0;
  int fails = 0;

  // Reference model: what each array should hold and what each unit should report.
  logic [7:0] exp_mem [2][8];
  logic [7:0] exp_rdata [2];
  logic       exp_err [2];

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [7:0] cells [8];
    logic [7:0] rd_val;

    mem8x8_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 7)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req[g]),
      .req_op   (req_op[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .ready    (ready[g]),
      .done     (done[g]),
      .rdata    (rdata[g]),
      .err      (err[g]),
      .mem_sel  (mem_sel[g]),
      .mem_op   (mem_op[g]),
      .mem_inp  (mem_inp[g]),
      .mem_outp (mem_outp[g])
    );

    initial for (int i = 0; i < 8; i++) cells[i] = 8'h00;

    always @(posedge clk) begin
      if (mem_op[g])
        for (int i = 0; i < 8; i++)
          if (mem_sel[g][i]) cells[i] <= mem_inp[g] ^ corrupt[g];
    end

    always_comb begin
      rd_val = 8'h00;
      if (!mem_op[g])
        for (int i = 0; i < 8; i++)
          if (mem_sel[g][i]) rd_val = rd_val | cells[i];
    end
    assign mem_outp[g] = rd_val;
  end

  // One transaction on unit u, started just after a negedge; returns on the negedge where ready is due.
  task automatic do_txn(input int u, input bit op, input bit [2:0] a, input bit [7:0] d, input bit keep);
    int w, lat;
    bit rbw, in_acc;
    logic [7:0] onehot, exp_sel;
    logic exp_mop;
    w = (u == 0) ? 1 : 7;
    rbw = RB && op;
    lat = rbw ? 2 * (2 + w) : 2 + w;
    onehot = 8'd1 << a;
    if (op) begin
      exp_mem[u][a] = d ^ corrupt[u];
      if (rbw) exp_err[u] = (corrupt[u] != 8'h00);
    end else begin
      exp_rdata[u] = exp_mem[u][a];
    end
    req[u] = 1'b1; req_op[u] = op; req_addr[u] = a; req_wdata[u] = d;
    @(posedge clk); #1;
    if (!keep) req[u] = 1'b0;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      in_acc = (n >= 2 && n <= 1 + w) || (rbw && n >= 4 + w && n <= 3 + 2 * w);
      exp_sel = in_acc ? onehot : 8'h00;
      exp_mop = (n <= 2 + w) ? op : 1'b0;
      tests++;
      if (mem_sel[u] !== exp_sel) begin
        fails++; $display("FAIL mem_sel u%0d cyc%0d: got %h want %h", u, n, mem_sel[u], exp_sel);
      end
      tests++;
      if (done[u] !== (n == lat)) begin
        fails++; $display("FAIL done u%0d cyc%0d: got %b want %b", u, n, done[u], (n == lat));
      end
      tests++;
      if (ready[u] !== (n == lat + 1)) begin
        fails++; $display("FAIL ready u%0d cyc%0d: got %b want %b", u, n, ready[u], (n == lat + 1));
      end
      if (n <= lat) begin
        tests++;
        if (mem_op[u] !== exp_mop || mem_inp[u] !== d) begin
          fails++; $display("FAIL mem_op/inp u%0d cyc%0d: got %b/%h want %b/%h", u, n, mem_op[u], mem_inp[u], exp_mop, d);
        end
      end
      if (n == lat) begin
        tests++;
        if (rdata[u] !== exp_rdata[u] || err[u] !== exp_err[u]) begin
          fails++; $display("FAIL result u%0d: got rdata %h err %b want %h %b", u, rdata[u], err[u], exp_rdata[u], exp_err[u]);
        end
      end
      if (keep && n <= lat) begin
        req_op[u] = 1'($urandom); req_addr[u] = 3'($urandom); req_wdata[u] = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({mem_sel[u], mem_op[u], mem_inp[u], rdata[u], done[u], err[u]} !== 27'd0) begin
        fails++; $display("FAIL reset_outputs u%0d: sel %h op %b inp %h rdata %h done %b err %b want all 0",
                          u, mem_sel[u], mem_op[u], mem_inp[u], rdata[u], done[u], err[u]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #0;
    for (int u = 0; u < 2; u++) begin
      tests++;
      if (ready[u] !== 1'b1) begin
        fails++; $display("FAIL reset_ready u%0d: got %b want 1", u, ready[u]);
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 3'd3, 8'hA5, 1'b0);
    do_txn(0, 1'b0, 3'd3, 8'h00, 1'b0);
    tests++;
    if (rdata[0] !== 8'hA5) begin
      fails++; $display("FAIL read_a5: got %h want a5", rdata[0]);
    end
    do_txn(0, 1'b1, 3'd5, 8'h5A, 1'b0);
    tests++;
    if (rdata[0] !== 8'hA5) begin
      fails++; $display("FAIL rdata_hold: got %h want a5", rdata[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++)
      do_txn($urandom_range(0, 1), 1'($urandom), 3'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++)
      do_txn(0, 1'($urandom), 3'($urandom), 8'($urandom), 1'b1);
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++)
      do_txn(1, 1'($urandom), 3'($urandom), 8'($urandom), 1'b1);
    req[1] = 1'b0;
  endtask

  task automatic test_long_wait();
    do_txn(1, 1'b1, 3'd7, 8'hC3, 1'b0);
    do_txn(1, 1'b0, 3'd7, 8'h11, 1'b0);
    tests++;
    if (rdata[1] !== 8'hC3) begin
      fails++; $display("FAIL long_read: got %h want c3", rdata[1]);
    end
  endtask

  task automatic test_readback();
    corrupt[0] = 8'h01;
    do_txn(0, 1'b1, 3'd4, 8'h3C, 1'b0);
    tests++;
    if (err[0] !== 1'b1) begin
      fails++; $display("FAIL readback_bad: got err %b want 1", err[0]);
    end
    corrupt[0] = 8'h00;
    do_txn(0, 1'b1, 3'd4, 8'h3C, 1'b0);
    tests++;
    if (err[0] !== 1'b0) begin
      fails++; $display("FAIL readback_good: got err %b want 0", err[0]);
    end
  endtask

  task automatic test_reset_mid_access();
    req[1] = 1'b1; req_op[1] = 1'b1; req_addr[1] = 3'd2; req_wdata[1] = 8'h77;
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_sel[1] !== 8'h04) begin
      fails++; $display("FAIL mid_sel_before: got %h want 04", mem_sel[1]);
    end
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({mem_sel[u], mem_op[u], mem_inp[u], rdata[u], done[u], err[u]} !== 27'd0) begin
        fails++; $display("FAIL mid_reset u%0d: sel %h op %b inp %h rdata %h done %b err %b want all 0",
                          u, mem_sel[u], mem_op[u], mem_inp[u], rdata[u], done[u], err[u]);
      end
      exp_rdata[u] = 8'h00;
      exp_err[u] = 1'b0;
    end
    exp_mem[1][2] = 8'h77;
    @(negedge clk);
    rst = 1'b0;
    #0;
    tests++;
    if (ready[1] !== 1'b1) begin
      fails++; $display("FAIL mid_ready: got %b want 1", ready[1]);
    end
    do_txn(1, 1'b0, 3'd6, 8'h00, 1'b0);
    do_txn(1, 1'b1, 3'd2, 8'h9E, 1'b0);
    do_txn(1, 1'b0, 3'd2, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; req_op[u] = 1'b0; req_addr[u] = 3'd0; req_wdata[u] = 8'h00;
      corrupt[u] = 8'h00; exp_rdata[u] = 8'h00; exp_err[u] = 1'b0;
      for (int i = 0; i < 8; i++) exp_mem[u][i] = 8'h00;
    end
    #1 rst = 1'b1;
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_long_wait();
    if (RB) test_readback();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem8x8_ctrl.md
MEM8X8_CTRL -- requirements
Module: mem8x8_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, setting the number of cycles mem_sel is held asserted per access; legal range 1..7.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 1 bit, transaction request, sampled only while ready=1.
REQ-005 The block SHALL have port req_op, input, 1 bit, 1=write, 0=read.
REQ-006 The block SHALL have port req_addr, input, 3 bits, byte address 0..7.
REQ-007 The block SHALL have port req_wdata, input, 8 bits, write data.
REQ-008 The block SHALL have port ready, output, 1 bit, high when idle and able to accept req.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, 8 bits, last read result.
REQ-011 The block SHALL have port err, output, 1 bit, readback mismatch flag (see Configuration).
REQ-012 The block SHALL have port mem_sel, output, 8 bits, one-hot byte-cell select.
REQ-013 The block SHALL have port mem_op, output, 1 bit, byte-cell operation, write=1, read=0.
REQ-014 The block SHALL have port mem_inp, output, 8 bits, byte-cell input data.
REQ-015 The block SHALL have port mem_outp, input, 8 bits, array read data (OR of all byte-cell outputs).

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS and RELEASE; ready=1 only in IDLE.
REQ-017 IDLE with req=1 SHALL latch req_op, req_addr and req_wdata, then go to SETUP; req outside IDLE SHALL be ignored.
REQ-018 SETUP SHALL last one cycle, with mem_op and mem_inp driven from latched values and mem_sel=0.
REQ-019 ACCESS SHALL last exactly WAIT_CYCLES cycles, with mem_sel = one-hot(latched addr) and mem_op and mem_inp unchanged.
REQ-020 RELEASE SHALL last one cycle, with mem_sel=0, mem_op and mem_inp held, and done=1; the next state SHALL be IDLE.
REQ-021 Total latency from the accepting edge to done high SHALL be 2+WAIT_CYCLES cycles; the next req SHALL be accepted no earlier than the cycle after done.
REQ-022 For reads, rdata SHALL capture mem_outp on the edge that ends the last ACCESS cycle; it SHALL hold that value until the next read capture; writes SHALL not alter rdata.
REQ-023 mem_sel SHALL never have more than one bit set, and SHALL never change in the same cycle as mem_op or mem_inp.
REQ-024 The WAIT_CYCLES counter SHALL be 3 bits and reload on every ACCESS entry.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force state IDLE, mem_sel=0, mem_op=0, mem_inp=0, rdata=0, done=0, err=0, with ready=1 after release.
REQ-026 Reset mid-ACCESS SHALL deassert mem_sel at once; the addressed byte content is then undefined.
REQ-027 req asserted on the first edge after rst falls SHALL be accepted.

Configuration
REQ-028 With macro MEM8X8_CTRL_READBACK_EN defined, each write SHALL be followed by a second SETUP/ACCESS/RELEASE pass at the same address with mem_op=0, before done.
REQ-029 In that second pass, err SHALL be set to 1 if the captured data differs from the written data, else 0; err SHALL hold until the next write completes.
REQ-030 In that second pass, write latency SHALL become 2*(2+WAIT_CYCLES) cycles and done SHALL pulse only at the final RELEASE; rdata SHALL be unchanged.
REQ-031 Without the macro, err SHALL be tied to 0 and writes SHALL take a single pass.

Verification
REQ-032 Reset then write addr=3, data=0xA5, WAIT_CYCLES=1 -> mem_sel=0x08 for one cycle, done 3 cycles after acceptance, ready back the next cycle.
REQ-033 Read addr=3 with mem_outp model returning 0xA5 -> rdata=0xA5 at done, held through a subsequent write to addr 5.
REQ-034 req held high continuously -> back-to-back transactions accepted only in IDLE, and no overlapping mem_sel pulses.
REQ-035 WAIT_CYCLES=7, write addr=7 -> mem_sel=0x80 for exactly 7 cycles, done 9 cycles after acceptance.
REQ-036 Assert rst in the 2nd ACCESS cycle -> mem_sel=0 in the same cycle, all outputs at reset values, ready=1 after release.
REQ-037 With MEM8X8_CTRL_READBACK_EN, write 0x3C with model storing 0x3D -> err=1, done at cycle 6 (WAIT_CYCLES=1); rewrite with correct storage -> err=0.
